instruction_fetch_unit: RTL and testbench

- Sits directly downstream of program_counter.
- Each cycle it samples the PC's out_address and issues a single-outstanding read request to instruction memory. It pulses INC_PC back to the PC when the read is accepted.
- Returned 19-bit instruction words, tagged with their address, are buffered in a small prefetch queue. The decode stage drains the queue through a valid/ready handshake.
- A flush input (PC redirect, i.e. LOAD_REG with LOAD_SELECT=LOAD_PC) discards buffered and in-flight fetches.

---
 rtl/instruction_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory reads from the PC,
// results buffered in a first-word fall-through prefetch queue.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 19,
    parameter int DEPTH       = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [ADDR_WIDTH-1:0]  pc_addr,
    input  logic                   fetch_en,
    input  logic                   flush,
    output logic                   inc_pc,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   ir_valid,
    output logic [INSTR_WIDTH-1:0] ir_data,
    output logic [ADDR_WIDTH-1:0]  ir_addr,
    input  logic                   ir_ready,
    output logic                   busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [INSTR_WIDTH-1:0] data_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  addr_q [DEPTH];
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [CW-1:0]          count;

    logic launch;
    logic push;
    logic pop;

    // Launch only with room reserved, so the single in-flight push never overflows
    assign launch = (state == IDLE) && fetch_en && !flush && (count < FULL);
    assign push   = inc_pc;
    assign pop    = ir_valid && ir_ready && !flush;

    assign ir_valid = (count != '0);
    assign ir_data  = data_q[rd_ptr];
    assign ir_addr  = addr_q[rd_ptr];

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a flush during a pending request must still drain the ack
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (launch) next_state = REQ;
            REQ: begin
                if (mem_ack)    next_state = IDLE;
                else if (flush) next_state = DROP;
            end
            DROP: if (mem_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state; inc_pc only for an ack that is kept
    always_comb begin
        mem_req = (state == REQ) || (state == DROP);
        busy    = (state != IDLE);
        inc_pc  = (state == REQ) && mem_ack && !flush;
    end

    // Request address captured at launch and held through REQ/DROP
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_addr <= '0;
        end else if (launch) begin
            mem_addr <= pc_addr;
        end
    end

    // Prefetch queue storage, pointers and occupancy
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= mem_rdata;
                addr_q[wr_ptr] <= mem_addr;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: linear steps, each
// checked against hand-computed values with immediate assertions.
module tb_instruction_fetch_unit;

    logic        CLK;
    logic        RST_N;
    logic [15:0] pc_addr;
    logic        fetch_en;
    logic        flush;
    logic        inc_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [18:0] mem_rdata;
    logic        ir_valid;
    logic [18:0] ir_data;
    logic [15:0] ir_addr;
    logic        ir_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_unit #(
        .ADDR_WIDTH (16),
        .INSTR_WIDTH(19),
        .DEPTH      (2)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .pc_addr  (pc_addr),
        .fetch_en (fetch_en),
        .flush    (flush),
        .inc_pc   (inc_pc),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .ir_valid (ir_valid),
        .ir_data  (ir_data),
        .ir_addr  (ir_addr),
        .ir_ready (ir_ready),
        .busy     (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N     = 1'b0;
        pc_addr   = 16'h0000;
        fetch_en  = 1'b0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        ir_ready  = 1'b0;
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_inc_pc", inc_pc, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_ir_data", ir_data, 0);
        chk("rst_ir_addr", ir_addr, 0);
        chk("rst_busy", busy, 0);

        // Zero-wait fetch of address 0
        RST_N    = 1'b1;
        fetch_en = 1'b1;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 19'h00001;
        #1;
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 16'h0000);
        chk("t1_inc_pc", inc_pc, 1);
        chk("t1_busy", busy, 1);
        tick();
        mem_ack = 1'b0;
        pc_addr = 16'h0001;
        #1;
        chk("t1_ir_valid", ir_valid, 1);
        chk("t1_ir_data", ir_data, 19'h00001);
        chk("t1_ir_addr", ir_addr, 16'h0000);
        chk("t1_inc_pc_off", inc_pc, 0);
        chk("t1_mem_req_off", mem_req, 0);

        // Fill the queue with ir_ready low
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 19'h00002;
        #1;
        chk("t3_mem_addr1", mem_addr, 16'h0001);
        chk("t3_inc_pc1", inc_pc, 1);
        tick();
        mem_ack = 1'b0;
        pc_addr = 16'h0002;
        #1;
        chk("t3_hold_data", ir_data, 19'h00001);
        chk("t3_hold_addr", ir_addr, 16'h0000);
        tick();
        chk("t3_full_noreq_a", mem_req, 0);
        chk("t3_full_busy", busy, 0);
        tick();
        chk("t3_full_noreq_b", mem_req, 0);
        chk("t3_hold_data_b", ir_data, 19'h00001);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        #1;
        chk("t3_pop_data", ir_data, 19'h00002);
        chk("t3_pop_addr", ir_addr, 16'h0001);
        chk("t3_pop_noreq", mem_req, 0);
        tick();
        chk("t3_refetch_req", mem_req, 1);
        chk("t3_refetch_addr", mem_addr, 16'h0002);
        mem_ack   = 1'b1;
        mem_rdata = 19'h00003;
        #1;
        chk("t3_refetch_inc", inc_pc, 1);
        tick();
        mem_ack  = 1'b0;
        pc_addr  = 16'h0003;
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        #1;
        chk("t4_head_addr", ir_addr, 16'h0002);
        chk("t4_head_data", ir_data, 19'h00003);

        // Flush while a request waits on memory
        tick();
        chk("t4_req", mem_req, 1);
        chk("t4_req_addr", mem_addr, 16'h0003);
        chk("t4_valid_pre", ir_valid, 1);
        flush   = 1'b1;
        pc_addr = 16'h0040;
        #1;
        chk("t4_flush_inc", inc_pc, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("t4_valid_post", ir_valid, 0);
        chk("t4_drop_req", mem_req, 1);
        chk("t4_drop_addr", mem_addr, 16'h0003);
        chk("t4_drop_busy", busy, 1);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 19'h7FFFF;
        #1;
        chk("t4_drop_inc", inc_pc, 0);
        chk("t4_drop_req2", mem_req, 1);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("t4_no_push", ir_valid, 0);
        chk("t4_idle", busy, 0);
        tick();
        chk("t4_redirect_req", mem_req, 1);
        chk("t4_redirect_addr", mem_addr, 16'h0040);
        mem_ack   = 1'b1;
        mem_rdata = 19'h12345;
        #1;
        chk("t4_redirect_inc", inc_pc, 1);
        tick();
        mem_ack = 1'b0;
        pc_addr = 16'h1234;
        #1;
        chk("t4_r_valid", ir_valid, 1);
        chk("t4_r_addr", ir_addr, 16'h0040);
        chk("t4_r_data", ir_data, 19'h12345);

        // Three-cycle ack latency; ack coincides with a pop
        tick();
        chk("t2_c1_req", mem_req, 1);
        chk("t2_c1_addr", mem_addr, 16'h1234);
        chk("t2_c1_inc", inc_pc, 0);
        tick();
        chk("t2_c2_req", mem_req, 1);
        chk("t2_c2_inc", inc_pc, 0);
        tick();
        chk("t2_c3_req", mem_req, 1);
        chk("t2_c3_addr", mem_addr, 16'h1234);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 19'h00ABC;
        ir_ready  = 1'b1;
        #1;
        chk("t2_c4_req", mem_req, 1);
        chk("t2_c4_addr", mem_addr, 16'h1234);
        chk("t2_c4_inc", inc_pc, 1);
        tick();
        mem_ack  = 1'b0;
        ir_ready = 1'b0;
        pc_addr  = 16'h1235;
        #1;
        chk("t2_req_end", mem_req, 0);
        chk("t5_pp_valid", ir_valid, 1);
        chk("t5_pp_addr", ir_addr, 16'h1234);
        chk("t5_pp_data", ir_data, 19'h00ABC);
        tick();
        chk("t5_launch", mem_req, 1);
        chk("t5_launch_addr", mem_addr, 16'h1235);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        #1;
        chk("t5_count1_empty", ir_valid, 0);

        // Flush coincident with ack
        mem_ack   = 1'b1;
        mem_rdata = 19'h55555;
        flush     = 1'b1;
        #1;
        chk("t5_fa_inc", inc_pc, 0);
        tick();
        mem_ack = 1'b0;
        flush   = 1'b0;
        pc_addr = 16'h0050;
        #1;
        chk("t5_fa_nopush", ir_valid, 0);
        chk("t5_fa_idle", busy, 0);
        tick();
        chk("t6_req", mem_req, 1);
        chk("t6_req_addr", mem_addr, 16'h0050);

        // Asynchronous reset mid-request
        #2;
        RST_N = 1'b0;
        #1;
        chk("t6_rst_req", mem_req, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_valid", ir_valid, 0);
        chk("t6_rst_addr", mem_addr, 0);
        #2;
        RST_N = 1'b1;
        tick();
        chk("t6_resume_req", mem_req, 1);
        chk("t6_resume_addr", mem_addr, 16'h0050);
        mem_ack   = 1'b1;
        mem_rdata = 19'h0BEEF;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("t6_resume_valid", ir_valid, 1);
        chk("t6_resume_data", ir_data, 19'h0BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
